seg_bcd_counter_disp: RTL and testbench

- Sits directly downstream of the clock manager.
- Consumes its 1 Hz and 200 Hz square-wave outputs as data inputs in the single clk_in domain. Both are synchronised and rising-edge detected.
- Runs a 4-digit BCD up/down counter stepped once per 1 Hz edge.
- Drives a 4-digit multiplexed common-anode seven-segment display, advancing one digit per 200 Hz edge.

---
 rtl/seg_bcd_counter_disp.sv | 187 ++++++++++++++++++
 tb/tb_seg_bcd_counter_disp.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_bcd_counter_disp.sv
// 4-digit BCD up/down counter stepped by a synchronised 1 Hz tick, driving a
// multiplexed common-anode seven-segment display scanned by a 200 Hz tick.
module seg_bcd_counter_disp #(
    parameter bit          LZ_BLANK = 1'b0,
    parameter logic [15:0] CNT_INIT = 16'h0000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        tick_1hz_in,
    input  logic        scan_200hz_in,
    input  logic        en,
    input  logic        clr,
    input  logic        up_down,
    output logic [15:0] count_bcd,
    output logic        carry_pulse,
    output logic [7:0]  seg,
    output logic [3:0]  dig_sel
);

    // Active-low segment pattern, dp off; illegal nibbles show blank.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = 8'hFF;
        endcase
        return pat;
    endfunction

    // Ripple a +1/-1 through the four BCD nibbles.
    function automatic logic [15:0] bcd_step(input logic [15:0] val, input logic up);
        logic [15:0] res;
        logic        cy;
        res = val;
        cy  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cy) begin
                if (up) begin
                    if (val[i*4 +: 4] == 4'd9) begin
                        res[i*4 +: 4] = 4'd0;
                        cy            = 1'b1;
                    end else begin
                        res[i*4 +: 4] = val[i*4 +: 4] + 4'd1;
                        cy            = 1'b0;
                    end
                end else begin
                    if (val[i*4 +: 4] == 4'd0) begin
                        res[i*4 +: 4] = 4'd9;
                        cy            = 1'b1;
                    end else begin
                        res[i*4 +: 4] = val[i*4 +: 4] - 4'd1;
                        cy            = 1'b0;
                    end
                end
            end else begin
                res[i*4 +: 4] = val[i*4 +: 4];
            end
        end
        return res;
    endfunction

    logic [2:0]  tick_sync_r;
    logic [2:0]  scan_sync_r;
    logic        tick_edge_s;
    logic        scan_edge_s;
    logic [15:0] count_r;
    logic        carry_r;
    logic [1:0]  idx_r;
    logic [7:0]  seg_r;
    logic [3:0]  dig_sel_r;
    logic [15:0] count_next_s;
    logic        wrap_s;
    logic [3:0]  nibble_s;
    logic        blank_s;
    logic [7:0]  seg_next_s;

    // Synchronisers preset high so a level already high at reset release is not an edge.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            tick_sync_r <= 3'b111;
            scan_sync_r <= 3'b111;
        end else begin
            tick_sync_r <= {tick_sync_r[1:0], tick_1hz_in};
            scan_sync_r <= {scan_sync_r[1:0], scan_200hz_in};
        end
    end

    assign tick_edge_s = tick_sync_r[1] & ~tick_sync_r[2];
    assign scan_edge_s = scan_sync_r[1] & ~scan_sync_r[2];

    // Next count value and wrap detection for the current direction.
    always_comb begin
        count_next_s = bcd_step(count_r, up_down);
        if (up_down) begin
            wrap_s = (count_r == 16'h9999);
        end else begin
            wrap_s = (count_r == 16'h0000);
        end
    end

    // Counter: clr outranks a coincident tick; ticks while disabled are dropped.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            count_r <= CNT_INIT;
            carry_r <= 1'b0;
        end else if (clr) begin
            count_r <= CNT_INIT;
            carry_r <= 1'b0;
        end else if (tick_edge_s && en) begin
            count_r <= count_next_s;
            carry_r <= wrap_s;
        end else begin
            count_r <= count_r;
            carry_r <= 1'b0;
        end
    end

    // Digit scan index, free-running on 200 Hz edges.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            idx_r <= 2'd0;
        end else if (scan_edge_s) begin
            idx_r <= idx_r + 2'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Select the scanned nibble and decide leading-zero blanking.
    always_comb begin
        nibble_s = 4'd0;
        blank_s  = 1'b0;
        case (idx_r)
            2'd0: begin
                nibble_s = count_r[3:0];
                blank_s  = 1'b0;
            end
            2'd1: begin
                nibble_s = count_r[7:4];
                blank_s  = LZ_BLANK && (count_r[15:4] == 12'h000);
            end
            2'd2: begin
                nibble_s = count_r[11:8];
                blank_s  = LZ_BLANK && (count_r[15:8] == 8'h00);
            end
            2'd3: begin
                nibble_s = count_r[15:12];
                blank_s  = LZ_BLANK && (count_r[15:12] == 4'h0);
            end
            default: begin
                nibble_s = 4'd0;
                blank_s  = 1'b1;
            end
        endcase
        if (blank_s) begin
            seg_next_s = 8'hFF;
        end else begin
            seg_next_s = seg_decode(nibble_s);
        end
    end

    // Registered display drive, one cycle behind idx and count.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            seg_r     <= seg_decode(CNT_INIT[3:0]);
            dig_sel_r <= 4'b1110;
        end else begin
            seg_r     <= seg_next_s;
            dig_sel_r <= ~(4'b0001 << idx_r);
        end
    end

    assign count_bcd   = count_r;
    assign carry_pulse = carry_r;
    assign seg         = seg_r;
    assign dig_sel     = dig_sel_r;

endmodule

// File: tb/tb_seg_bcd_counter_disp.sv
// Directed bench for seg_bcd_counter_disp: four instances cover default,
// wrap preload, plain display and leading-zero blanking configurations.
module tb_seg_bcd_counter_disp;

    logic clk_in = 1'b0;
    logic rst, scan_200hz_in, en, clr, up_down;
    logic tick_main, tick_wrap, tick_idle;
    logic [15:0] cnt_m, cnt_w, cnt_d, cnt_l;
    logic        cy_m, cy_w, cy_d, cy_l;
    logic [7:0]  seg_m, seg_w, seg_d, seg_l;
    logic [3:0]  dig_m, dig_w, dig_d, dig_l;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    seg_bcd_counter_disp u_main (
        .clk_in(clk_in), .rst(rst), .tick_1hz_in(tick_main), .scan_200hz_in(scan_200hz_in),
        .en(en), .clr(clr), .up_down(up_down), .count_bcd(cnt_m), .carry_pulse(cy_m),
        .seg(seg_m), .dig_sel(dig_m));

    seg_bcd_counter_disp #(.CNT_INIT(16'h9998)) u_wrap (
        .clk_in(clk_in), .rst(rst), .tick_1hz_in(tick_wrap), .scan_200hz_in(scan_200hz_in),
        .en(en), .clr(clr), .up_down(up_down), .count_bcd(cnt_w), .carry_pulse(cy_w),
        .seg(seg_w), .dig_sel(dig_w));

    seg_bcd_counter_disp #(.LZ_BLANK(1'b0), .CNT_INIT(16'h0305)) u_disp (
        .clk_in(clk_in), .rst(rst), .tick_1hz_in(tick_idle), .scan_200hz_in(scan_200hz_in),
        .en(en), .clr(clr), .up_down(up_down), .count_bcd(cnt_d), .carry_pulse(cy_d),
        .seg(seg_d), .dig_sel(dig_d));

    seg_bcd_counter_disp #(.LZ_BLANK(1'b1), .CNT_INIT(16'h0007)) u_lz (
        .clk_in(clk_in), .rst(rst), .tick_1hz_in(tick_idle), .scan_200hz_in(scan_200hz_in),
        .en(en), .clr(clr), .up_down(up_down), .count_bcd(cnt_l), .carry_pulse(cy_l),
        .seg(seg_l), .dig_sel(dig_l));

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[3:0]   = 4'(n % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[15:12] = 4'((n / 1000) % 10);
        return r;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Raise the main tick and let it take effect (3 edges), then drop it and settle.
    task automatic main_tick();
        tick_main = 1'b1;
        cycles(3);
        tick_main = 1'b0;
        cycles(3);
    endtask

    task automatic wrap_tick_rise();
        tick_wrap = 1'b1;
        cycles(3);
    endtask

    task automatic wrap_tick_fall();
        tick_wrap = 1'b0;
        cycles(3);
    endtask

    task automatic scan_pulse();
        scan_200hz_in = 1'b1;
        cycles(3);
        scan_200hz_in = 1'b0;
        cycles(3);
    endtask

    logic [7:0] exp_seg_d [4];
    logic [7:0] exp_seg_l [4];
    logic [3:0] exp_dig   [4];
    logic       carry_seen;

    initial begin
        exp_seg_d = '{8'h92, 8'hC0, 8'hB0, 8'hC0};
        exp_seg_l = '{8'hF8, 8'hFF, 8'hFF, 8'hFF};
        exp_dig   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // 1: reset with inputs held high, then 20 quiet cycles
        rst = 1'b1; tick_main = 1'b1; tick_wrap = 1'b1; tick_idle = 1'b0;
        scan_200hz_in = 1'b1; en = 1'b1; clr = 1'b0; up_down = 1'b1;
        cycles(3);
        rst = 1'b0;
        carry_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            carry_seen = carry_seen | cy_m | cy_w;
        end
        check_val("rst_count", cnt_m, 16'h0000);
        check_val("rst_dig", {12'h0, dig_m}, 16'h000E);
        check_val("rst_seg", {8'h0, seg_m}, 16'h00C0);
        check_val("rst_no_carry", {15'h0, carry_seen}, 16'h0000);
        check_val("rst_wrap_init", cnt_w, 16'h9998);
        tick_main = 1'b0; tick_wrap = 1'b0; scan_200hz_in = 1'b0;
        cycles(3);

        // 3: wrap instance 9998 -> 9999 -> 0000 (carry) -> 9999 (carry, down)
        wrap_tick_rise();
        check_val("wrap_9999", cnt_w, 16'h9999);
        check_val("wrap_9999_cy", {15'h0, cy_w}, 16'h0000);
        wrap_tick_fall();
        wrap_tick_rise();
        check_val("wrap_0000", cnt_w, 16'h0000);
        check_val("wrap_up_cy", {15'h0, cy_w}, 16'h0001);
        cycles(1);
        check_val("wrap_cy_1cyc", {15'h0, cy_w}, 16'h0000);
        wrap_tick_fall();
        up_down = 1'b0;
        wrap_tick_rise();
        check_val("wrap_dn_9999", cnt_w, 16'h9999);
        check_val("wrap_dn_cy", {15'h0, cy_w}, 16'h0001);
        wrap_tick_fall();
        up_down = 1'b1;

        // 2: 12 up ticks on main, each landing exactly on the 3rd edge
        for (int n = 0; n < 12; n++) begin
            tick_main = 1'b1;
            cycles(2);
            check_val("lat_edge2", cnt_m, to_bcd(n));
            cycles(1);
            check_val("lat_edge3", cnt_m, to_bcd(n + 1));
            tick_main = 1'b0;
            cycles(3);
        end
        check_val("count_0012", cnt_m, 16'h0012);

        // 4: run up to 0457, then clr coincident with a tick
        for (int n = 12; n < 457; n++) main_tick();
        check_val("count_0457", cnt_m, 16'h0457);
        tick_main = 1'b1;
        cycles(2);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        check_val("clr_count", cnt_m, 16'h0000);
        check_val("clr_no_cy", {15'h0, cy_m}, 16'h0000);
        tick_main = 1'b0;
        cycles(3);
        check_val("clr_tick_lost", cnt_m, 16'h0000);
        en = 1'b0;
        for (int n = 0; n < 3; n++) main_tick();
        check_val("en0_hold", cnt_m, 16'h0000);
        en = 1'b1;

        // 6: count to 0042, move scan, then reset mid-flight with inputs high
        for (int n = 0; n < 42; n++) main_tick();
        check_val("count_0042", cnt_m, 16'h0042);
        scan_pulse();
        scan_pulse();
        check_val("pre_rst_dig", {12'h0, dig_m}, 16'h000B);
        tick_main = 1'b1; scan_200hz_in = 1'b1;
        cycles(1);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check_val("mid_rst_count", cnt_m, 16'h0000);
        check_val("mid_rst_dig", {12'h0, dig_m}, 16'h000E);
        check_val("mid_rst_seg", {8'h0, seg_m}, 16'h00C0);
        cycles(6);
        check_val("post_rst_no_tick", cnt_m, 16'h0000);
        check_val("post_rst_no_scan", {12'h0, dig_m}, 16'h000E);
        tick_main = 1'b0; scan_200hz_in = 1'b0;
        cycles(3);

        // 5: scan through 0305 (no blanking) and 0007 (blanking), 8 edges
        check_val("disp_cnt", cnt_d, 16'h0305);
        check_val("lz_cnt", cnt_l, 16'h0007);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) scan_pulse();
            check_val("disp_dig", {12'h0, dig_d}, {12'h0, exp_dig[k % 4]});
            check_val("disp_seg", {8'h0, seg_d}, {8'h0, exp_seg_d[k % 4]});
            check_val("lz_seg", {8'h0, seg_l}, {8'h0, exp_seg_l[k % 4]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
